// File: rtl/izh_pkg.sv
// Shared definitions for the synaptic-current scheduler: default widths,
// scheduler FSM states and the signed current/weight value type.
package izh_pkg;

  localparam int NUMWIDTH_DEF = 16;
  localparam int TAGBITS_DEF  = 1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_SWAP  = 2'd2,
    ST_DONE  = 2'd3
  } sched_state_e;

  typedef logic signed [NUMWIDTH_DEF:0] value_t;

endpackage

// File: rtl/current_scheduler_if.sv
// Bundle of requester handshakes, timestep control and next-current store
// access used by current_scheduler.
interface current_scheduler_if #(
  parameter int NUMWIDTH = izh_pkg::NUMWIDTH_DEF,
  parameter int TAGBITS  = izh_pkg::TAGBITS_DEF,
  parameter int NUMREQ   = 4
);

  // Requester k transfers its tag/weight on a rising clk edge where
  // req_valid[k] and req_ready[k] are both high; valid must not depend on
  // ready, and at most one ready bit is high per cycle.
  logic [NUMREQ-1:0]              req_valid;
  logic [NUMREQ*TAGBITS-1:0]      req_tag;
  logic [NUMREQ*(NUMWIDTH+1)-1:0] req_weight;
  logic [NUMREQ-1:0]              req_ready;

  logic step_req;
  logic step_done;
  logic swap;

  logic [TAGBITS-1:0] i_next_read_tag;
  logic [NUMWIDTH:0]  i_next_read_value;
  logic               i_next_write_en;
  logic [TAGBITS-1:0] i_next_write_tag;
  logic [NUMWIDTH:0]  i_next_write_value;

  modport slave (
    input  req_valid, req_tag, req_weight, step_req, i_next_read_value,
    output req_ready, step_done, swap, i_next_read_tag,
           i_next_write_en, i_next_write_tag, i_next_write_value
  );

  modport master (
    output req_valid, req_tag, req_weight, step_req, i_next_read_value,
    input  req_ready, step_done, swap, i_next_read_tag,
           i_next_write_en, i_next_write_tag, i_next_write_value
  );

endinterface

// File: rtl/current_scheduler_rr_arbiter.sv
// Round-robin arbiter (module rr_arbiter): one-hot grant searching upward
// from ptr, and the pointer to use after this cycle.
module rr_arbiter #(
  parameter int NUMREQ = 4,
  parameter int PTRW   = (NUMREQ > 1) ? $clog2(NUMREQ) : 1
) (
  input  logic [NUMREQ-1:0] valid,
  input  logic [PTRW-1:0]   ptr,
  output logic [NUMREQ-1:0] grant,
  output logic [PTRW-1:0]   next_ptr
);

  int   idx;
  logic found;

  // With no grant the pointer holds; otherwise it moves past the winner.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUMREQ; i++) begin
      idx = (int'(ptr) + i) % NUMREQ;
      if (!found && valid[idx]) begin
        grant[idx] = 1'b1;
        next_ptr   = PTRW'((idx + 1) % NUMREQ);
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/current_scheduler.sv
// Accumulates requester weights into the next-timestep current store through
// a 2-stage read-modify-write, then swaps stores on step_req.
// Build option: CURRENT_SCHEDULER_SAT_EN selects saturating instead of wrapping sums.
module current_scheduler
  import izh_pkg::*;
#(
  parameter int NUMWIDTH = NUMWIDTH_DEF,
  parameter int TAGBITS  = TAGBITS_DEF,
  parameter int NUMREQ   = 4,
  localparam int PTRW    = (NUMREQ > 1) ? $clog2(NUMREQ) : 1
) (
  input  logic               clk,
  input  logic               asyn_reset,
  current_scheduler_if.slave bus,
  output sched_state_e       dbg_state,
  output logic [PTRW-1:0]    dbg_ptr
);

  localparam int VW = NUMWIDTH + 1;

  sched_state_e state_q, state_d;
  logic [PTRW-1:0]   ptr_q, ptr_nxt;
  logic [NUMREQ-1:0] arb_valid, grant;
  logic              grant_en, accept;
  logic [TAGBITS-1:0] sel_tag;
  logic [VW-1:0]      sel_weight;

  logic               a_valid;
  logic [TAGBITS-1:0] a_tag;
  logic [VW-1:0]      a_weight;

  logic               b_valid;
  logic [TAGBITS-1:0] b_tag;
  logic [VW-1:0]      b_weight;
  logic               b_fwd;
  logic [VW-1:0]      b_fwd_val;
  logic [VW-1:0]      operand, b_sum;

  assign grant_en  = (state_q == ST_RUN) && !bus.step_req && !asyn_reset;
  assign arb_valid = grant_en ? bus.req_valid : '0;

  rr_arbiter #(.NUMREQ(NUMREQ), .PTRW(PTRW)) u_arb (
    .valid    (arb_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (ptr_nxt)
  );

  assign accept        = |grant;
  assign bus.req_ready = grant;

  always_comb begin
    sel_tag    = '0;
    sel_weight = '0;
    for (int k = 0; k < NUMREQ; k++) begin
      if (grant[k]) begin
        sel_tag    = bus.req_tag[k*TAGBITS +: TAGBITS];
        sel_weight = bus.req_weight[k*VW +: VW];
      end
    end
  end

  // The store read sampled alongside a same-tag write returns the old value,
  // so that write's sum is captured and used instead.
  assign operand = b_fwd ? b_fwd_val : bus.i_next_read_value;

`ifdef CURRENT_SCHEDULER_SAT_EN
  logic [VW:0] wide_sum;
  always_comb begin
    wide_sum = {b_weight[VW-1], b_weight} + {operand[VW-1], operand};
    b_sum    = wide_sum[VW-1:0];
    if (wide_sum[VW] != wide_sum[VW-1])
      b_sum = wide_sum[VW] ? {1'b1, {NUMWIDTH{1'b0}}} : {1'b0, {NUMWIDTH{1'b1}}};
  end
`else
  assign b_sum = b_weight + operand;
`endif

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      ptr_q     <= '0;
      a_valid   <= 1'b0;
      a_tag     <= '0;
      a_weight  <= '0;
      b_valid   <= 1'b0;
      b_tag     <= '0;
      b_weight  <= '0;
      b_fwd     <= 1'b0;
      b_fwd_val <= '0;
    end else begin
      ptr_q   <= ptr_nxt;
      a_valid <= accept;
      if (accept) begin
        a_tag    <= sel_tag;
        a_weight <= sel_weight;
      end
      b_valid <= a_valid;
      if (a_valid) begin
        b_tag     <= a_tag;
        b_weight  <= a_weight;
        b_fwd     <= b_valid && (b_tag == a_tag);
        b_fwd_val <= b_sum;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) state_q <= ST_RUN;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.step_req) state_d = ST_DRAIN;
      ST_DRAIN: if (!a_valid && !b_valid) state_d = ST_SWAP;
      ST_SWAP:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  assign bus.swap               = (state_q == ST_SWAP) && !b_valid && !asyn_reset;
  assign bus.step_done          = (state_q == ST_DONE) && !asyn_reset;
  assign bus.i_next_read_tag    = a_tag;
  assign bus.i_next_write_en    = b_valid && !asyn_reset;
  assign bus.i_next_write_tag   = bus.i_next_write_en ? b_tag : '0;
  assign bus.i_next_write_value = bus.i_next_write_en ? b_sum : '0;

  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule

// File: tb/tb_current_scheduler.sv
// Directed bench for current_scheduler: store model, write scoreboard,
// arbitration, step sequencing and reset checks.
module tb_current_scheduler;
  import izh_pkg::*;

  localparam int NUMWIDTH = NUMWIDTH_DEF;
  localparam int TAGBITS  = TAGBITS_DEF;
  localparam int NUMREQ   = 4;
  localparam int VW       = NUMWIDTH + 1;
  localparam int W        = TAGBITS + VW;
  localparam int PTRW     = 2;

  logic clk = 1'b0;
  logic asyn_reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   swap_cnt = 0;
  int   done_cnt = 0;

  current_scheduler_if #(.NUMWIDTH(NUMWIDTH), .TAGBITS(TAGBITS), .NUMREQ(NUMREQ)) bus ();
  sched_state_e    dbg_state;
  logic [PTRW-1:0] dbg_ptr;

  current_scheduler #(.NUMWIDTH(NUMWIDTH), .TAGBITS(TAGBITS), .NUMREQ(NUMREQ)) dut (
    .clk        (clk),
    .asyn_reset (asyn_reset),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_ptr    (dbg_ptr)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // next-current store model: registered read, write after read on the same edge
  logic [VW-1:0]      mem [2**TAGBITS];
  logic [VW-1:0]      rd_q;
  logic               pre_we;
  logic [TAGBITS-1:0] pre_tag;
  logic [VW-1:0]      pre_val;

  always @(posedge clk) begin
    rd_q <= mem[bus.i_next_read_tag];
    if (pre_we) mem[pre_tag] <= pre_val;
    else if (bus.i_next_write_en) mem[bus.i_next_write_tag] <= bus.i_next_write_value;
  end
  assign bus.i_next_read_value = rd_q;

  logic [TAGBITS-1:0] t_arr [NUMREQ];
  value_t             w_arr [NUMREQ];

  always_comb begin
    bus.req_tag    = '0;
    bus.req_weight = '0;
    for (int k = 0; k < NUMREQ; k++) begin
      bus.req_tag[k*TAGBITS +: TAGBITS] = t_arr[k];
      bus.req_weight[k*VW +: VW]        = w_arr[k];
    end
  end

  // scoreboard
  logic [W-1:0]  exp_q [$];
  int            lat_q [$];
  logic [VW-1:0] model_mem [2**TAGBITS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] model_add(input logic [VW-1:0] a, input logic [VW-1:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef CURRENT_SCHEDULER_SAT_EN
    if (s > (longint'(1) << NUMWIDTH) - 1) s = (longint'(1) << NUMWIDTH) - 1;
    else if (s < -(longint'(1) << NUMWIDTH)) s = -(longint'(1) << NUMWIDTH);
`endif
    return s[VW-1:0];
  endfunction

  always @(negedge clk) begin
    if (bus.i_next_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL unexpected_write: observed tag %0d value 0x%0h, required no write",
               bus.i_next_write_tag, bus.i_next_write_value);
      end else begin
        check("write", 32'({bus.i_next_write_tag, bus.i_next_write_value}), 32'(exp_q.pop_front()));
        check("write_latency", 32'(cyc), 32'(lat_q.pop_front()));
      end
    end
    if (bus.swap === 1'b1) begin
      swap_cnt++;
      check("swap_no_write", 32'(bus.i_next_write_en), 32'd0);
    end
    if (bus.step_done === 1'b1) done_cnt++;
  end

  // driver tasks: entered and left 1 time unit after a rising edge
  task automatic preload(input logic [TAGBITS-1:0] tag, input logic [VW-1:0] val);
    pre_we  = 1'b1;
    pre_tag = tag;
    pre_val = val;
    model_mem[tag] = val;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic drive(input logic [NUMREQ-1:0] v, input int exp_k);
    logic [VW-1:0] nv;
    bus.req_valid = v;
    @(negedge clk);
    check("grant", 32'(bus.req_ready), (exp_k < 0) ? 32'd0 : (32'd1 << exp_k));
    if (exp_k >= 0) begin
      nv = model_add(model_mem[t_arr[exp_k]], w_arr[exp_k]);
      model_mem[t_arr[exp_k]] = nv;
      exp_q.push_back({t_arr[exp_k], nv});
      lat_q.push_back(cyc + 2);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, -1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int swap_at, done_at, sc0, dc0;
    logic found;
    asyn_reset    = 1'b1;
    bus.req_valid = '1;
    bus.step_req  = 1'b0;
    pre_we = 1'b0; pre_tag = '0; pre_val = '0;
    for (int k = 0; k < NUMREQ; k++) begin
      t_arr[k] = '0;
      w_arr[k] = '0;
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_ready",     32'(bus.req_ready), 32'd0);
    check("rst_write_en",  32'(bus.i_next_write_en), 32'd0);
    check("rst_swap",      32'(bus.swap), 32'd0);
    check("rst_step_done", 32'(bus.step_done), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(ST_RUN));
    check("rst_ptr",       32'(dbg_ptr), 32'd0);
    check("rst_rd_tag",    32'(bus.i_next_read_tag), 32'd0);
    check("rst_wr_tag",    32'(bus.i_next_write_tag), 32'd0);
    check("rst_wr_val",    32'(bus.i_next_write_value), 32'd0);
    @(posedge clk); #1;
    asyn_reset    = 1'b0;
    bus.req_valid = '0;

    preload(1'b1, 17'd5);
    preload(1'b0, 17'd0);

    // single op: 5 + 3 -> 8 on tag 1
    t_arr[0] = 1'b1; w_arr[0] = 17'sd3;
    drive(4'b0001, 0);
    idle(4);

    // back-to-back on tag 0: 2, 5, 4
    t_arr[1] = 1'b0; w_arr[1] = 17'sd2;
    drive(4'b0010, 1);
    t_arr[2] = 1'b0; w_arr[2] = 17'sd3;
    drive(4'b0100, 2);
    t_arr[3] = 1'b0; w_arr[3] = -17'sd1;
    drive(4'b1000, 3);
    idle(4);

    // fairness from p=0
    for (int k = 0; k < NUMREQ; k++) begin
      t_arr[k] = TAGBITS'(k % 2);
      w_arr[k] = value_t'(k + 1);
    end
    for (int i = 0; i < 5; i++) drive(4'b1111, i % 4);
    idle(4);
    check("ptr_after_fair", 32'(dbg_ptr), 32'd1);

    // arithmetic edges
    preload(1'b1, 17'd32760);
    t_arr[1] = 1'b1; w_arr[1] = 17'sd100;
    drive(4'b0010, 1);
    idle(4);
    preload(1'b0, 17'h0FFFF);
    t_arr[2] = 1'b0; w_arr[2] = 17'sd1;
    drive(4'b0100, 2);
    idle(4);
    preload(1'b1, 17'h10000);
    t_arr[3] = 1'b1; w_arr[3] = -17'sd1;
    drive(4'b1000, 3);
    idle(4);

    // step with two ops in flight
    t_arr[0] = 1'b1; w_arr[0] = -17'sd5;
    drive(4'b1001, 0);
    t_arr[1] = 1'b1; w_arr[1] = 17'sd7;
    drive(4'b0010, 1);
    bus.step_req  = 1'b1;
    bus.req_valid = '1;
    sc0 = swap_cnt;
    swap_at = -1;
    done_at = -1;
    for (int i = 0; i < 20 && done_at < 0; i++) begin
      @(negedge clk);
      check("step_no_grant", 32'(bus.req_ready), 32'd0);
      if (bus.swap === 1'b1) swap_at = cyc;
      if (bus.step_done === 1'b1) done_at = cyc;
      @(posedge clk); #1;
    end
    if (done_at < 0) begin
      tests++;
      fails++;
      $error("FAIL step_timeout: observed no step_done within 20 cycles, required one");
    end
    bus.step_req  = 1'b0;
    bus.req_valid = '0;
    check("step_swap_count", 32'(swap_cnt - sc0), 32'd1);
    check("step_done_after_swap", 32'(done_at), 32'(swap_at + 1));
    check("step_queue_drained", 32'(exp_q.size()), 32'd0);
    check("step_ptr_hold", 32'(dbg_ptr), 32'd2);
    check("step_state_run", 32'(dbg_state), 32'(ST_RUN));

    // reset while in SWAP
    bus.step_req = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (dbg_state == ST_SWAP) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!found) begin
      tests++;
      fails++;
      $error("FAIL swap_wait_timeout: observed no SWAP state within 20 cycles, required one");
    end
    sc0 = swap_cnt;
    dc0 = done_cnt;
    asyn_reset = 1'b1;
    @(negedge clk);
    check("rst_in_swap_swap", 32'(bus.swap), 32'd0);
    check("rst_in_swap_done", 32'(bus.step_done), 32'd0);
    @(posedge clk); #1;
    asyn_reset   = 1'b0;
    bus.step_req = 1'b0;
    check("rst_in_swap_state", 32'(dbg_state), 32'(ST_RUN));
    check("rst_in_swap_ptr", 32'(dbg_ptr), 32'd0);
    @(negedge clk);
    check("rst_in_swap_done_after", 32'(bus.step_done), 32'd0);
    @(posedge clk); #1;
    check("rst_in_swap_no_swaps", 32'(swap_cnt - sc0), 32'd0);
    check("rst_in_swap_no_dones", 32'(done_cnt - dc0), 32'd0);

    // normal operation resumes after reset
    t_arr[0] = 1'b0; w_arr[0] = 17'sd1;
    drive(4'b0001, 0);
    idle(4);
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
